apb_master: RTL

//   APB initiator: turns a valid/ready request/response port (CPU load/store or DMA side) into
//   APB transfers with SETUP/ACCESS phasing, wait-state handling and a bounded-wait timeout.

---
 rtl/apb_master_if.sv | 26 ++
 rtl/apb_master.sv | 125 ++++++++++++
 2 files changed

// File: rtl/apb_master_if.sv
// APB bus bundle between the initiator and the fabric.
//   master modport: drives psel/penable/paddr/pwrite/pwdata/pwstrb; samples pready/prdata/pslverr
//   slave modport : the mirror image, for a slave model or fabric decoder
interface apb_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic              pready;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pwstrb;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// APB initiator: converts a valid/ready request/response port into single APB transfers
// (SETUP then ACCESS), waits for pready and aborts after TIMEOUT ACCESS cycles (0 = never).
// One transfer outstanding at a time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_addr/write/wdata/wstrb payload
//   rsp_valid/rsp_ready           response handshake; rsp_rdata/rsp_err payload
//   apb (apb_master_if.master)    APB bus; all outputs come straight from flops
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    apb_master_if.master      apb
);
    // Counter must hold 0..TIMEOUT-1; keep at least one bit when timeouts are disabled.
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              psel_q, penable_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [CntW-1:0]   cnt_q;

    logic timeout_hit;
    logic accept;
    logic rsp_done;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; pready takes priority over an expiring timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (apb.pready || timeout_hit) state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Decoded outputs and handshake strobes
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        accept    = (state_q == StIdle) && req_valid;
        rsp_done  = (state_q == StResp) && rsp_ready;
    end

    // Datapath and registered APB outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // psel/penable follow the upcoming state so they change on the same edge
            psel_q    <= (state_d == StSetup) || (state_d == StAccess);
            penable_q <= (state_d == StAccess);

            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
                wstrb_q <= req_write ? req_wstrb : 4'h0;
            end

            if (state_q == StAccess) begin
                cnt_q <= cnt_q + CntW'(1);
                if (apb.pready) begin
                    err_q   <= apb.pslverr;
                    rdata_q <= write_q ? 32'h0 : apb.prdata;
                end else if (timeout_hit) begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'h0;
                end
            end else if (rsp_done) begin
                cnt_q <= '0;
            end
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.paddr   = addr_q;
    assign apb.pwrite  = write_q;
    assign apb.pwdata  = wdata_q;
    assign apb.pwstrb  = wstrb_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
endmodule
